serial_fsub: RTL
================

// Module: serial_fsub
// PURPOSE
//  Bit-serial two's-complement subtractor: Diff = A - B, LSB first, one full-subtractor
//  cell per clock with a registered borrow. Counterpart of the combinational full-adder
//  cells in the adders library. Trades WIDTH cycles of latency for a single cell.
//  Start/Busy/Done handshake for use by small datapath controllers.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  Clk     in   1      rising-edge clock, the only clock
//  Rst_n   in   1      asynchronous, active-low reset
//  Start   in   1      request; sampled on Clk when idle (IDLE or DONE)
//  A       in   WIDTH  minuend, captured on the accepted Start edge
//  B       in   WIDTH  subtrahend, captured on the accepted Start edge
//  Busy    out  1      high while bits are being computed
//  Done    out  1      one-cycle pulse: Diff/Borrow valid
//  Diff    out  WIDTH  result A-B mod 2^WIDTH, held until next Done
//  Borrow  out  1      final borrow out: 1 iff A < B unsigned
// BEHAVIOUR
//  - Reset (async, Rst_n=0): state=IDLE, Busy=0, Done=0, Diff=0, Borrow=0, count=0,
//    internal shift regs and borrow FF cleared. Applies immediately, including mid-operation.
//    An aborted operation produces no Done. Diff/Borrow read 0 after reset.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE:  Start=1 -> load sa<=A, sb<=B, bf<=0, count<=0; go to SHIFT.
//    SHIFT: each edge: a=sa[0], b=sb[0];
//           d    = a ^ b ^ bf;
//           bout = (~a & b) | (~(a ^ b) & bf);
//           sd  <= {d, sd[WIDTH-1:1]}; sa, sb shift right; bf <= bout; count++.
//           On the edge that processes bit WIDTH-1: Diff <= final sd, Borrow <= bout;
//           go to DONE.
//    DONE:  Done=1 for exactly this cycle. Start=1 here is accepted exactly as in IDLE
//           (back-to-back operation); otherwise go to IDLE.
//  - Busy = (state==SHIFT); Done = (state==DONE); both decoded from registered state.
//  - Latency: Start accepted at edge k -> Done high in the cycle after edge k+WIDTH;
//    Busy high for WIDTH cycles. Throughput: one result per WIDTH+1 cycles.
//  - Start while Busy: ignored; A/B changes while Busy: ignored (operands were captured).
//  - Diff/Borrow update only on SHIFT->DONE; stable at all other times.
//  - count is $clog2(WIDTH)+1 bits wide; no wrap within an operation.
// CONFIGURATION
//  SERIAL_FSUB_OVF_EN defined: extra output port Ovf (out, 1). Ovf is the signed
//    overflow, registered with Diff on SHIFT->DONE:
//    Ovf = (A[W-1] != B[W-1]) && (Diff[W-1] != A[W-1]), using the captured operand
//    MSBs (retained in a dedicated FF). Ovf resets to 0 and is held like Diff.
//  Not defined: no Ovf port, no extra logic; all other behaviour identical.
// TESTING (WIDTH=8)
//  1. A=0x35, B=0x12, Start pulse -> Busy 8 cycles, Done 1 cycle later; Diff=0x23, Borrow=0.
//  2. A=0x00, B=0x01 -> Diff=0xFF, Borrow=1; A=0xA5, B=0xA5 -> Diff=0x00, Borrow=0.
//  3. Start held high continuously with A=0x10, B=0x01 -> a result every 9 cycles, each
//     Diff=0x0F; Start and operand changes while Busy have no effect on the running op.
//  4. Rst_n low for 1 cycle at the 4th SHIFT cycle -> outputs 0 at once, no Done; a new
//     op (A=0x80, B=0x7F) completes normally with Diff=0x01, Borrow=0.
//  5. SERIAL_FSUB_OVF_EN: A=0x80, B=0x01 -> Diff=0x7F, Ovf=1; A=0x05, B=0x03 -> Ovf=0.
//  6. Random A/B, 1000 ops vs. reference model (A-B) & 0xFF, Borrow=(A<B); Done count
//     equals accepted Start count.

Source files
------------

// File: rtl/serial_fsub.sv
// Bit-serial two's-complement subtractor (Diff = A - B), LSB first, one cell per clock.
// Optional signed-overflow output Ovf when SERIAL_FSUB_OVF_EN is defined.
module serial_fsub #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_FSUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, sd;
    logic             bf;
    logic [CW-1:0]    count;
`ifdef SERIAL_FSUB_OVF_EN
    logic             msb_a, msb_b;
`endif

    logic             a, b, d, bout;
    logic [WIDTH-1:0] sd_next;
    logic             last;

    always_comb begin
        a       = sa[0];
        b       = sb[0];
        d       = a ^ b ^ bf;
        bout    = (~a & b) | (~(a ^ b) & bf);
        sd_next = {d, sd[WIDTH-1:1]};
        last    = (count == CW'(WIDTH - 1));
    end

    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bf     <= 1'b0;
            count  <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
`ifdef SERIAL_FSUB_OVF_EN
            msb_a  <= 1'b0;
            msb_b  <= 1'b0;
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts Start exactly like IDLE for back-to-back operation
                    if (Start) begin
                        sa    <= A;
                        sb    <= B;
                        bf    <= 1'b0;
                        count <= '0;
`ifdef SERIAL_FSUB_OVF_EN
                        msb_a <= A[WIDTH-1];
                        msb_b <= B[WIDTH-1];
`endif
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sd    <= sd_next;
                    bf    <= bout;
                    count <= count + CW'(1);
                    if (last) begin
                        Diff   <= sd_next;
                        Borrow <= bout;
`ifdef SERIAL_FSUB_OVF_EN
                        // d of the last cell is the result MSB
                        Ovf    <= (msb_a != msb_b) && (d != msb_a);
`endif
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
